of_issue_interlock: RTL and testbench

Operand-fetch/execute boundary register with a full register and flag interlock; it sits directly upstream of the execute stage. It holds one fetched instruction in the OF slot and tracks the instructions in EX, MA and RW in internal shadow slots. Each cycle it issues the OF instruction into EX, or injects a NOP bubble while any in-flight instruction still owes a register or flags result. It also discards wrong-path instructions on a taken branch and keeps a saturating stall-cycle counter.

---
 rtl/of_isa_pkg.sv | 88 ++++++++
 rtl/of_dep_check.sv | 31 +++
 rtl/of_issue_interlock.sv | 136 +++++++++++++
 tb/tb_of_issue_interlock.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/of_isa_pkg.sv
// ISA decode helpers for the operand-fetch issue interlock.
// Holds opcode encodings, instruction field positions, the bubble encoding,
// the OF slot state type and pure predicates describing which registers and
// flags an instruction reads and writes.
package of_isa_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h6800_0000;

    // Field positions
    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 27;
    localparam int unsigned I_BIT  = 26;
    localparam int unsigned RD_HI  = 25;
    localparam int unsigned RD_LO  = 22;
    localparam int unsigned RS1_HI = 21;
    localparam int unsigned RS1_LO = 18;
    localparam int unsigned RS2_HI = 17;
    localparam int unsigned RS2_LO = 14;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_CMP  = 5'b00101;
    localparam logic [4:0] OP_NOT  = 5'b01000;
    localparam logic [4:0] OP_MOV  = 5'b01001;
    localparam logic [4:0] OP_NOP  = 5'b01101;
    localparam logic [4:0] OP_LD   = 5'b01110;
    localparam logic [4:0] OP_ST   = 5'b01111;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BGT  = 5'b10001;
    localparam logic [4:0] OP_B    = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_RET  = 5'b10100;

    typedef enum logic [1:0] {OfEmpty, OfFull, OfStall} of_state_e;

    function automatic logic [4:0] opc(input logic [31:0] ins);
        return ins[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [3:0] rd_f(input logic [31:0] ins);
        return ins[RD_HI:RD_LO];
    endfunction

    function automatic logic [3:0] rs1_f(input logic [31:0] ins);
        return ins[RS1_HI:RS1_LO];
    endfunction

    function automatic logic [3:0] rs2_f(input logic [31:0] ins);
        return ins[RS2_HI:RS2_LO];
    endfunction

    function automatic logic reads_rs1(input logic [31:0] ins);
        return !(opc(ins) inside {OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_MOV, OP_NOT,
                                  OP_RET});
    endfunction

    function automatic logic reads_rs2(input logic [31:0] ins);
        return !ins[I_BIT] &&
               !(opc(ins) inside {OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_RET, OP_ST});
    endfunction

    // ST sources its store data from the rd field
    function automatic logic reads_rd(input logic [31:0] ins);
        return opc(ins) == OP_ST;
    endfunction

    // RET takes its return address from r15
    function automatic logic reads_r15(input logic [31:0] ins);
        return opc(ins) == OP_RET;
    endfunction

    function automatic logic reads_flags(input logic [31:0] ins);
        return opc(ins) inside {OP_BEQ, OP_BGT};
    endfunction

    function automatic logic writes_reg(input logic [31:0] ins);
        return !(opc(ins) inside {OP_NOP, OP_CMP, OP_ST, OP_B, OP_BEQ, OP_BGT, OP_RET});
    endfunction

    function automatic logic [3:0] dest_reg(input logic [31:0] ins);
        return (opc(ins) == OP_CALL) ? 4'd15 : rd_f(ins);
    endfunction

    function automatic logic writes_flags(input logic [31:0] ins);
        return opc(ins) == OP_CMP;
    endfunction

endpackage

// File: rtl/of_dep_check.sv
// Combinational dependency check of the OF instruction against one
// in-flight slot.
//   of_instr    : instruction held in the OF slot
//   slot_valid  : in-flight slot holds a real instruction
//   slot_instr  : in-flight instruction
//   dep         : slot owes a register or flags result the OF instruction reads
module of_dep_check
    import of_isa_pkg::*;
(
    input  logic [31:0] of_instr,
    input  logic        slot_valid,
    input  logic [31:0] slot_instr,
    output logic        dep
);

    logic [3:0] d;
    logic       reg_hit;
    logic       flag_hit;

    always_comb begin
        d        = dest_reg(slot_instr);
        reg_hit  = writes_reg(slot_instr) &&
                   ((reads_rs1(of_instr) && rs1_f(of_instr) == d) ||
                    (reads_rs2(of_instr) && rs2_f(of_instr) == d) ||
                    (reads_rd(of_instr)  && rd_f(of_instr)  == d) ||
                    (reads_r15(of_instr) && d == 4'd15));
        flag_hit = writes_flags(slot_instr) && reads_flags(of_instr);
        dep      = slot_valid && (reg_hit || flag_hit);
    end

endmodule

// File: rtl/of_issue_interlock.sv
// Operand-fetch / execute boundary register with register and flag interlock.
// Holds one instruction in OF, shadows EX/MA/RW, issues into EX or injects a
// NOP bubble while any in-flight instruction owes a result the OF instruction
// reads. A taken branch flushes OF and EX. Counts stall cycles (saturating).
//   clk, rst          : clock, async active-high reset
//   if_valid/instr/pc : fetch side; if_ready accepts
//   branch_taken      : flush request from EX
//   ex_valid/instr/pc : registered instruction entering EX
//   stall             : OF held this cycle by a hazard
//   stall_count       : saturating stall-cycle counter
module of_issue_interlock
    import of_isa_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    input  logic [31:0]            if_instr,
    input  logic [31:0]            if_pc,
    output logic                   if_ready,
    input  logic                   branch_taken,
    output logic                   ex_valid,
    output logic [31:0]            ex_instr,
    output logic [31:0]            ex_pc,
    output logic                   stall,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [STALL_CNT_W-1:0] CntOne = 1;

    of_state_e   state;
    logic [31:0] of_instr;
    logic [31:0] of_pc;
    logic        ma_valid;
    logic [31:0] ma_instr;
    logic        rw_valid;
    logic [31:0] rw_instr;

    logic of_valid;
    logic dep_ex;
    logic dep_ma;
    logic dep_rw;
    logic hazard;

    of_dep_check u_dep_ex (
        .of_instr   (of_instr),
        .slot_valid (ex_valid),
        .slot_instr (ex_instr),
        .dep        (dep_ex)
    );

    of_dep_check u_dep_ma (
        .of_instr   (of_instr),
        .slot_valid (ma_valid),
        .slot_instr (ma_instr),
        .dep        (dep_ma)
    );

    // No RW bypass into the register file, so RW is checked too
    of_dep_check u_dep_rw (
        .of_instr   (of_instr),
        .slot_valid (rw_valid),
        .slot_instr (rw_instr),
        .dep        (dep_rw)
    );

    always_comb begin
        of_valid = (state != OfEmpty);
        hazard   = of_valid && (dep_ex || dep_ma || dep_rw);
        stall    = hazard && !branch_taken;
        if_ready = !branch_taken && (!of_valid || !hazard);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= OfEmpty;
            of_instr    <= NOP_INSTR;
            of_pc       <= '0;
            ex_valid    <= 1'b0;
            ex_instr    <= NOP_INSTR;
            ex_pc       <= '0;
            ma_valid    <= 1'b0;
            ma_instr    <= NOP_INSTR;
            rw_valid    <= 1'b0;
            rw_instr    <= NOP_INSTR;
            stall_count <= '0;
        end else begin
            rw_valid <= ma_valid;
            rw_instr <= ma_instr;
            ma_valid <= ex_valid;
            ma_instr <= ex_instr;
            // Bubble unless something issues below
            ex_valid <= 1'b0;
            ex_instr <= NOP_INSTR;
            ex_pc    <= '0;

            if (branch_taken) begin
                state    <= OfEmpty;
                of_instr <= NOP_INSTR;
                of_pc    <= '0;
            end else begin
                case (state)
                    OfEmpty: begin
                        if (if_valid) begin
                            state    <= OfFull;
                            of_instr <= if_instr;
                            of_pc    <= if_pc;
                        end
                    end
                    OfFull, OfStall: begin
                        if (hazard) begin
                            state <= OfStall;
                            if (stall_count != '1) begin
                                stall_count <= stall_count + CntOne;
                            end
                        end else begin
                            ex_valid <= 1'b1;
                            ex_instr <= of_instr;
                            ex_pc    <= of_pc;
                            if (if_valid) begin
                                state    <= OfFull;
                                of_instr <= if_instr;
                                of_pc    <= if_pc;
                            end else begin
                                state <= OfEmpty;
                            end
                        end
                    end
                    default: state <= OfEmpty;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_of_issue_interlock.sv
module tb_of_issue_interlock;

    localparam logic [31:0] NOP = 32'h6800_0000;

    // Opcodes (independent copy for the reference model)
    localparam logic [4:0] CMP = 5'd5, NOTO = 5'd8, MOV = 5'd9, NOPO = 5'd13, ST = 5'd15;
    localparam logic [4:0] BEQ = 5'd16, BGT = 5'd17, BR = 5'd18, CALL = 5'd19, RET = 5'd20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = 32'h0;
    logic [31:0] if_pc = 32'h0;
    logic        branch_taken = 1'b0;
    logic        if_ready, ex_valid, stall;
    logic [31:0] ex_instr, ex_pc;
    logic [15:0] stall_count;
    logic        if_ready_s, ex_valid_s, stall_s;
    logic [31:0] ex_instr_s, ex_pc_s;
    logic [3:0]  stall_count_s;

    always #5 clk = ~clk;

    of_issue_interlock u_dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_ready     (if_ready),
        .branch_taken (branch_taken),
        .ex_valid     (ex_valid),
        .ex_instr     (ex_instr),
        .ex_pc        (ex_pc),
        .stall        (stall),
        .stall_count  (stall_count)
    );

    // Narrow counter instance so saturation is reachable in a short run
    of_issue_interlock #(.STALL_CNT_W(4)) u_dut_sat (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_ready     (if_ready_s),
        .branch_taken (branch_taken),
        .ex_valid     (ex_valid_s),
        .ex_instr     (ex_instr_s),
        .ex_pc        (ex_pc_s),
        .stall        (stall_s),
        .stall_count  (stall_count_s)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: OF slot plus an age-ordered array of in-flight slots
    logic        m_ofv;
    logic [31:0] m_of, m_ofpc, m_expc;
    logic        pv [3];
    logic [31:0] pi [3];
    logic [15:0] m_sc16;
    logic [3:0]  m_sc4;

    logic        obs_ready, obs_stall, obs_exv, last_acc;
    logic [31:0] obs_exi, obs_expc;
    logic [15:0] obs_sc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rd_mask(input logic [31:0] x);
        logic [15:0] m = '0;
        logic [4:0]  op = x[31:27];
        if (!(op inside {NOPO, BR, BEQ, BGT, CALL, MOV, NOTO, RET})) m[x[21:18]] = 1'b1;
        if (!x[26] && !(op inside {NOPO, BR, BEQ, BGT, CALL, RET, ST})) m[x[17:14]] = 1'b1;
        if (op == ST) m[x[25:22]] = 1'b1;
        if (op == RET) m[15] = 1'b1;
        return m;
    endfunction

    function automatic logic [15:0] wr_mask(input logic [31:0] x);
        logic [15:0] m = '0;
        logic [4:0]  op = x[31:27];
        if (!(op inside {NOPO, CMP, ST, BR, BEQ, BGT, RET})) begin
            if (op == CALL) m[15] = 1'b1;
            else m[x[25:22]] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic m_hazard();
        logic h = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (pv[s] && ((wr_mask(pi[s]) & rd_mask(m_of)) != 16'h0)) h = 1'b1;
            if (pv[s] && pi[s][31:27] == CMP && m_of[31:27] inside {BEQ, BGT}) h = 1'b1;
        end
        return m_ofv && h;
    endfunction

    task automatic model_reset();
        m_ofv = 1'b0; m_of = NOP; m_ofpc = '0; m_expc = '0;
        for (int s = 0; s < 3; s++) begin pv[s] = 1'b0; pi[s] = NOP; end
        m_sc16 = '0; m_sc4 = '0;
    endtask

    // One clock: drive at negedge, compare shortly after, advance model at posedge
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic b);
        logic hz, rdy, acc;
        @(negedge clk);
        if_valid = v; if_instr = ins; if_pc = pc; branch_taken = b;
        #1;
        hz  = m_hazard();
        rdy = !b && (!m_ofv || !hz);
        chk("if_ready", if_ready, rdy);
        chk("stall", stall, hz && !b);
        chk("ex_valid", ex_valid, pv[0]);
        chk("ex_instr", ex_instr, pi[0]);
        chk("ex_pc", ex_pc, m_expc);
        chk("stall_count", stall_count, m_sc16);
        chk("stall_count_w4", stall_count_s, m_sc4);
        chk("stall_w4", stall_s, hz && !b);
        obs_ready = if_ready; obs_stall = stall; obs_exv = ex_valid;
        obs_exi = ex_instr; obs_expc = ex_pc; obs_sc = stall_count;
        acc = v && rdy;
        last_acc = acc;
        pv[2] = pv[1]; pi[2] = pi[1];
        pv[1] = pv[0]; pi[1] = pi[0];
        pv[0] = 1'b0; pi[0] = NOP; m_expc = '0;
        if (b) begin
            m_ofv = 1'b0;
        end else if (m_ofv && !hz) begin
            pv[0] = 1'b1; pi[0] = m_of; m_expc = m_ofpc;
            m_ofv = acc;
            if (acc) begin m_of = ins; m_ofpc = pc; end
        end else if (m_ofv) begin
            if (m_sc16 != 16'hFFFF) m_sc16 = m_sc16 + 16'd1;
            if (m_sc4 != 4'hF) m_sc4 = m_sc4 + 4'd1;
        end else if (acc) begin
            m_ofv = 1'b1; m_of = ins; m_ofpc = pc;
        end
        @(posedge clk);
    endtask

    // Asserting reset must clear outputs at once, without waiting for a clock
    task automatic do_reset(input string tag);
        @(negedge clk);
        if_valid = 1'b0; branch_taken = 1'b0; rst = 1'b1;
        #1;
        chk({tag, "_ex_valid"}, ex_valid, 1'b0);
        chk({tag, "_ex_instr"}, ex_instr, NOP);
        chk({tag, "_ex_pc"}, ex_pc, 32'h0);
        chk({tag, "_stall"}, stall, 1'b0);
        chk({tag, "_stall_count"}, stall_count, 16'h0);
        chk({tag, "_if_ready"}, if_ready, 1'b1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present each instruction until accepted, drain, and return observed stalls
    task automatic run_seq(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input int n, input int exp_stalls);
        logic [31:0] prog [3];
        int stalls = 0;
        prog[0] = a; prog[1] = b; prog[2] = c;
        for (int k = 0; k < 6; k++) step(1'b0, NOP, 32'h0, 1'b0);
        for (int k = 0; k < n; k++) begin
            int guard = 0;
            do begin
                step(1'b1, prog[k], 32'h400 + 32'(k * 4), 1'b0);
                stalls += int'(obs_stall);
                guard++;
            end while (!last_acc && guard < 20);
            if (!last_acc) chk({nm, "_accept_timeout"}, 32'h0, 32'h1);
        end
        for (int k = 0; k < 6; k++) begin
            step(1'b0, NOP, 32'h0, 1'b0);
            stalls += int'(obs_stall);
        end
        chk({nm, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [4:0] ops [16] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8, 5'd9,
                                 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20};
        logic [4:0] op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 15)];
        logic [3:0] rd  = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
        logic [3:0] rs1 = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
        logic [3:0] rs2 = 4'($urandom_range(0, 3));
        return {op, 1'($urandom), rd, rs1, rs2, 14'($urandom)};
    endfunction

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        b;
        logic        e_ready;
        logic        e_stall;
        logic        e_exv;
        logic [31:0] e_exi;
        logic [31:0] e_expc;
        logic [15:0] e_sc;
    } vec_t;

    localparam logic [31:0] ADD1 = 32'h0048_C000;  // ADD r1,r2,r3
    localparam logic [31:0] ADD4 = 32'h0105_4000;  // ADD r4,r1,r5

    initial begin
        vec_t tbl [13];
        // Back-to-back dependency, then a flush in the middle of a stall
        tbl[0]  = '{1'b1, ADD1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, NOP,  32'h0,   16'd0};
        tbl[1]  = '{1'b1, ADD4, 32'h104, 1'b0, 1'b1, 1'b0, 1'b0, NOP,  32'h0,   16'd0};
        tbl[2]  = '{1'b0, NOP,  32'h0,   1'b0, 1'b0, 1'b1, 1'b1, ADD1, 32'h100, 16'd0};
        tbl[3]  = '{1'b0, NOP,  32'h0,   1'b0, 1'b0, 1'b1, 1'b0, NOP,  32'h0,   16'd1};
        tbl[4]  = '{1'b0, NOP,  32'h0,   1'b0, 1'b0, 1'b1, 1'b0, NOP,  32'h0,   16'd2};
        tbl[5]  = '{1'b0, NOP,  32'h0,   1'b0, 1'b1, 1'b0, 1'b0, NOP,  32'h0,   16'd3};
        tbl[6]  = '{1'b0, NOP,  32'h0,   1'b0, 1'b1, 1'b0, 1'b1, ADD4, 32'h104, 16'd3};
        tbl[7]  = '{1'b1, ADD1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0, NOP,  32'h0,   16'd3};
        tbl[8]  = '{1'b1, ADD4, 32'h204, 1'b0, 1'b1, 1'b0, 1'b0, NOP,  32'h0,   16'd3};
        tbl[9]  = '{1'b0, NOP,  32'h0,   1'b0, 1'b0, 1'b1, 1'b1, ADD1, 32'h200, 16'd3};
        tbl[10] = '{1'b1, ADD1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, NOP,  32'h0,   16'd4};
        tbl[11] = '{1'b0, NOP,  32'h0,   1'b0, 1'b1, 1'b0, 1'b0, NOP,  32'h0,   16'd4};
        tbl[12] = '{1'b0, NOP,  32'h0,   1'b0, 1'b1, 1'b0, 1'b0, NOP,  32'h0,   16'd4};

        model_reset();
        do_reset("reset");

        for (int k = 0; k < 13; k++) begin
            step(tbl[k].v, tbl[k].ins, tbl[k].pc, tbl[k].b);
            chk($sformatf("tbl%0d_if_ready", k), obs_ready, tbl[k].e_ready);
            chk($sformatf("tbl%0d_stall", k), obs_stall, tbl[k].e_stall);
            chk($sformatf("tbl%0d_ex_valid", k), obs_exv, tbl[k].e_exv);
            chk($sformatf("tbl%0d_ex_instr", k), obs_exi, tbl[k].e_exi);
            chk($sformatf("tbl%0d_ex_pc", k), obs_expc, tbl[k].e_expc);
            chk($sformatf("tbl%0d_stall_count", k), obs_sc, tbl[k].e_sc);
        end

        // ADD r1 ; SUB r6,r7,r8 ; ADD r4,r1,r5
        run_seq("add_sub_add", ADD1, 32'h099E_0000, ADD4, 3, 2);
        // CMP r1,r2 then BEQ
        run_seq("cmp_beq", 32'h2804_8000, 32'h8000_0000, 32'h0, 2, 3);
        // MOV r2,#5 then ADD r3,r4,#7 (rs2 field = 2, immediate)
        run_seq("mov_addi", 32'h4C80_0005, 32'h04D0_8007, 32'h0, 2, 0);
        // CALL then RET
        run_seq("call_ret", 32'h9800_0000, 32'hA000_0000, 32'h0, 2, 3);
        // ADD r1 then ST r1,[r2]
        run_seq("add_st", ADD1, 32'h7848_0000, 32'h0, 2, 3);

        // Reset in the middle of a stall
        step(1'b1, ADD1, 32'h500, 1'b0);
        step(1'b1, ADD4, 32'h504, 1'b0);
        step(1'b0, NOP, 32'h0, 1'b0);
        do_reset("mid_stall_reset");
        step(1'b0, NOP, 32'h0, 1'b0);

        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 3) != 0), rnd_instr(), $urandom,
                 ($urandom_range(0, 11) == 0));
            if (k == 1500) do_reset("random_reset");
        end
        chk("w4_saturated", stall_count_s, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
